t_switch_allocator: RTL and testbench
=====================================

Name: t_switch_allocator

Overview:
- Three-port output allocator for one T-switch of the butterfly fat tree.
- Sits directly downstream of the per-input-port direction determiners and consumes their 2-bit direction codes (VOID/LEFT/RIGHT/UP from direction_params.vh) alongside each input packet.
- Arbitrates contention for the left, right and up output ports with per-output round-robin, and registers each winning packet into a one-entry output stage with valid/ready backpressure.
- Illegal routes are dropped and flagged.

Parameters:
- P_W, 32: packet width in bits; passed through unmodified.
- CNT_W, 8: width of the saturating dropped-packet counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- l_valid_i, r_valid_i, u_valid_i  in  1 each  input packet valid per port (left child, right child, parent).
- l_data_i, r_data_i, u_data_i  in  P_W each  input packets.
- l_dir_i, r_dir_i, u_dir_i  in  2 each  direction code from that port's direction determiner.
- l_ready_o, r_ready_o, u_ready_o  out  1 each  input accepted this cycle.
- l_valid_o, r_valid_o, u_valid_o  out  1 each  output register occupied.
- l_data_o, r_data_o, u_data_o  out  P_W each  output register contents.
- l_ready_i, r_ready_i, u_ready_i  in  1 each  downstream accepts the output.
- err_o  out  1  sticky illegal-route flag.
- drop_cnt_o  out  CNT_W  saturating count of dropped packets.

Behaviour:
- Reset (sync, active-high):
  - all *_valid_o = 0, *_data_o = 0, *_ready_o = 0;
  - err_o = 0, drop_cnt_o = 0;
  - all round-robin pointers = 0.
- Legal routes:
  - L input -> RIGHT or UP.
  - R input -> LEFT or UP.
  - U input -> LEFT or RIGHT.
- Illegal routes: U-turn (L->LEFT, R->RIGHT, U->UP), or valid with dir = VOID.
  - Illegal packet is accepted (ready_o = 1) in the same cycle, discarded, not written anywhere.
  - Next edge: err_o <= 1; drop_cnt_o += 1, saturating at all-ones.
  - Up to three drops in one cycle add their count, still saturating.
- Output slot free in a cycle if: out_valid = 0, or (out_valid & out_ready_i).
- Candidates per output:
  - out L: {R, U}, candidate 0 = R.
  - out R: {L, U}, candidate 0 = L.
  - out U: {L, R}, candidate 0 = L.
- Per-output pointer bit p selects the favoured candidate (p = 0 favours candidate 0).
  - Grant only if the slot is free.
  - If only one candidate requests, it wins regardless of p.
  - After a contested grant, p <= index of the loser. Uncontested grants leave p unchanged.
- Each input requests exactly one output, so each input gets at most one grant; ready_o = grant, combinational in the same cycle.
- Output register update on each edge:
  - granted: load data, valid <= 1;
  - else if out_ready_i & valid: valid <= 0;
  - else hold.
  - Data holds while valid & !ready_i.
- Latency: input accepted in cycle N appears on data_o/valid_o in N+1.
- Throughput: 1 packet/cycle/output, including simultaneous drain and refill of the same slot.
- Inputs with valid_i = 0 never request, whatever dir_i says.
- Reset asserted mid-transfer: all held packets are lost; nothing is granted in the reset cycle; ready_o = 0 while reset is high.
- err_o clears only on reset.

Test Plan:
- Single route: l_valid_i = 1, l_dir_i = UP, l_data_i = 0xA5A5_0001, u_ready_i = 1 -> l_ready_o = 1 same cycle; u_valid_o = 1, u_data_o = 0xA5A5_0001 next cycle; other outputs stay invalid.
- Contention and fairness: L and R both target UP every cycle, u_ready_i = 1, 4 cycles -> grants alternate L, R, L, R starting with L after reset; the loser's ready_o = 0 each cycle.
- Backpressure: u_ready_i = 0 with u_valid_o = 1 holding 0x11 and L requesting UP -> l_ready_o = 0, u_data_o stays 0x11. Raise u_ready_i -> same cycle l_ready_o = 1; new data on the next edge with no bubble.
- Full crossbar, no conflict: L->RIGHT, R->UP, U->LEFT at once, all downstream ready -> all three ready_o = 1; all three outputs valid next cycle with the correct data.
- Illegal routes: r_dir_i = RIGHT and u_dir_i = UP in one cycle -> both ready_o = 1, no output loaded, drop_cnt_o = 2, err_o = 1. With CNT_W = 2 and 5 drops -> drop_cnt_o = 3.
- Mid-operation reset: all outputs full and stalled, reset for 1 cycle -> all valid_o = 0, drop_cnt_o = 0, err_o = 0, pointers 0. First contested grant after reset goes to candidate 0.

Source files
------------

// File: rtl/t_switch_allocator.sv
// Three-port output allocator for one butterfly fat-tree T-switch.
// Per-output round-robin arbitration into one-entry valid/ready output stages.
module t_switch_allocator #(
    parameter int P_W   = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             l_valid_i,
    input  logic             r_valid_i,
    input  logic             u_valid_i,
    input  logic [P_W-1:0]   l_data_i,
    input  logic [P_W-1:0]   r_data_i,
    input  logic [P_W-1:0]   u_data_i,
    input  logic [1:0]       l_dir_i,
    input  logic [1:0]       r_dir_i,
    input  logic [1:0]       u_dir_i,
    output logic             l_ready_o,
    output logic             r_ready_o,
    output logic             u_ready_o,
    output logic             l_valid_o,
    output logic             r_valid_o,
    output logic             u_valid_o,
    output logic [P_W-1:0]   l_data_o,
    output logic [P_W-1:0]   r_data_o,
    output logic [P_W-1:0]   u_data_o,
    input  logic             l_ready_i,
    input  logic             r_ready_i,
    input  logic             u_ready_i,
    output logic             err_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam logic [1:0] VOID  = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;
    localparam logic [1:0] UP    = 2'd3;

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic l_req_r, l_req_u, r_req_l, r_req_u, u_req_l, u_req_r;
    logic l_ill, r_ill, u_ill;
    logic ol_free, or_free, ou_free;
    logic gl_r, gl_u, gr_l, gr_u, gu_l, gu_r;
    logic ptr_l, ptr_r, ptr_u;
    logic [1:0] n_drop;
    logic [CNT_W+1:0] cnt_sum;

    always_comb begin
        l_req_r = l_valid_i & (l_dir_i == RIGHT);
        l_req_u = l_valid_i & (l_dir_i == UP);
        r_req_l = r_valid_i & (r_dir_i == LEFT);
        r_req_u = r_valid_i & (r_dir_i == UP);
        u_req_l = u_valid_i & (u_dir_i == LEFT);
        u_req_r = u_valid_i & (u_dir_i == RIGHT);
        l_ill = l_valid_i & ((l_dir_i == VOID) | (l_dir_i == LEFT));
        r_ill = r_valid_i & ((r_dir_i == VOID) | (r_dir_i == RIGHT));
        u_ill = u_valid_i & ((u_dir_i == VOID) | (u_dir_i == UP));
    end

    // A slot can take a new packet while its current one drains.
    assign ol_free = ~l_valid_o | l_ready_i;
    assign or_free = ~r_valid_o | r_ready_i;
    assign ou_free = ~u_valid_o | u_ready_i;

    always_comb begin
        gl_r = ~reset & ol_free & r_req_l & (~u_req_l | ~ptr_l);
        gl_u = ~reset & ol_free & u_req_l & (~r_req_l | ptr_l);
        gr_l = ~reset & or_free & l_req_r & (~u_req_r | ~ptr_r);
        gr_u = ~reset & or_free & u_req_r & (~l_req_r | ptr_r);
        gu_l = ~reset & ou_free & l_req_u & (~r_req_u | ~ptr_u);
        gu_r = ~reset & ou_free & r_req_u & (~l_req_u | ptr_u);
    end

    assign l_ready_o = gr_l | gu_l | (~reset & l_ill);
    assign r_ready_o = gl_r | gu_r | (~reset & r_ill);
    assign u_ready_o = gl_u | gr_u | (~reset & u_ill);

    assign n_drop  = 2'(l_ill) + 2'(r_ill) + 2'(u_ill);
    assign cnt_sum = {2'b00, drop_cnt_o} + (CNT_W+2)'(n_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            l_valid_o  <= 1'b0;
            r_valid_o  <= 1'b0;
            u_valid_o  <= 1'b0;
            l_data_o   <= '0;
            r_data_o   <= '0;
            u_data_o   <= '0;
            ptr_l      <= 1'b0;
            ptr_r      <= 1'b0;
            ptr_u      <= 1'b0;
            err_o      <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (gl_r | gl_u) begin
                l_valid_o <= 1'b1;
                l_data_o  <= gl_r ? r_data_i : u_data_i;
            end else if (l_ready_i) begin
                l_valid_o <= 1'b0;
            end
            if (gr_l | gr_u) begin
                r_valid_o <= 1'b1;
                r_data_o  <= gr_l ? l_data_i : u_data_i;
            end else if (r_ready_i) begin
                r_valid_o <= 1'b0;
            end
            if (gu_l | gu_r) begin
                u_valid_o <= 1'b1;
                u_data_o  <= gu_l ? l_data_i : r_data_i;
            end else if (u_ready_i) begin
                u_valid_o <= 1'b0;
            end
            // A contested grant always goes to the favoured side,
            // so the loser index is the inverted pointer.
            if (ol_free & r_req_l & u_req_l) ptr_l <= ~ptr_l;
            if (or_free & l_req_r & u_req_r) ptr_r <= ~ptr_r;
            if (ou_free & l_req_u & r_req_u) ptr_u <= ~ptr_u;
            if (l_ill | r_ill | u_ill) err_o <= 1'b1;
            drop_cnt_o <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                              : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_t_switch_allocator.sv
// Directed bench for t_switch_allocator with a per-output expected queue.
// A second CNT_W=2 instance shares the inputs to exercise saturation.
module tb_t_switch_allocator;

    localparam logic [1:0] VOID  = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;
    localparam logic [1:0] UP    = 2'd3;

    logic clk = 1'b0;
    logic reset;
    logic l_valid_i, r_valid_i, u_valid_i;
    logic [31:0] l_data_i, r_data_i, u_data_i;
    logic [1:0] l_dir_i, r_dir_i, u_dir_i;
    logic l_ready_o, r_ready_o, u_ready_o;
    logic l_valid_o, r_valid_o, u_valid_o;
    logic [31:0] l_data_o, r_data_o, u_data_o;
    logic l_ready_i, r_ready_i, u_ready_i;
    logic err_o;
    logic [7:0] drop_cnt_o;

    logic s_l_ready_o, s_r_ready_o, s_u_ready_o;
    logic s_l_valid_o, s_r_valid_o, s_u_valid_o;
    logic [31:0] s_l_data_o, s_r_data_o, s_u_data_o;
    logic s_err_o;
    logic [1:0] s_drop_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q_l[$];
    logic [31:0] q_r[$];
    logic [31:0] q_u[$];
    logic        exp_v[3];
    logic [31:0] exp_d[3];
    logic        exp_err;
    int          exp_drop;
    int          exp_sdrop;

    always #5 clk = ~clk;

    t_switch_allocator dut (
        .clk(clk), .reset(reset),
        .l_valid_i(l_valid_i), .r_valid_i(r_valid_i), .u_valid_i(u_valid_i),
        .l_data_i(l_data_i), .r_data_i(r_data_i), .u_data_i(u_data_i),
        .l_dir_i(l_dir_i), .r_dir_i(r_dir_i), .u_dir_i(u_dir_i),
        .l_ready_o(l_ready_o), .r_ready_o(r_ready_o), .u_ready_o(u_ready_o),
        .l_valid_o(l_valid_o), .r_valid_o(r_valid_o), .u_valid_o(u_valid_o),
        .l_data_o(l_data_o), .r_data_o(r_data_o), .u_data_o(u_data_o),
        .l_ready_i(l_ready_i), .r_ready_i(r_ready_i), .u_ready_i(u_ready_i),
        .err_o(err_o), .drop_cnt_o(drop_cnt_o)
    );

    t_switch_allocator #(.P_W(32), .CNT_W(2)) sat (
        .clk(clk), .reset(reset),
        .l_valid_i(l_valid_i), .r_valid_i(r_valid_i), .u_valid_i(u_valid_i),
        .l_data_i(l_data_i), .r_data_i(r_data_i), .u_data_i(u_data_i),
        .l_dir_i(l_dir_i), .r_dir_i(r_dir_i), .u_dir_i(u_dir_i),
        .l_ready_o(s_l_ready_o), .r_ready_o(s_r_ready_o), .u_ready_o(s_u_ready_o),
        .l_valid_o(s_l_valid_o), .r_valid_o(s_r_valid_o), .u_valid_o(s_u_valid_o),
        .l_data_o(s_l_data_o), .r_data_o(s_r_data_o), .u_data_o(s_u_data_o),
        .l_ready_i(l_ready_i), .r_ready_i(r_ready_i), .u_ready_i(u_ready_i),
        .err_o(s_err_o), .drop_cnt_o(s_drop_cnt_o)
    );

    function automatic int illegal(input logic v, input logic [1:0] d,
                                   input logic [1:0] own);
        return (v && (d == VOID || d == own)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("l_valid_o", 32'(l_valid_o), 32'(exp_v[0]));
        chk("r_valid_o", 32'(r_valid_o), 32'(exp_v[1]));
        chk("u_valid_o", 32'(u_valid_o), 32'(exp_v[2]));
        chk("l_data_o", l_data_o, exp_d[0]);
        chk("r_data_o", r_data_o, exp_d[1]);
        chk("u_data_o", u_data_o, exp_d[2]);
        chk("err_o", 32'(err_o), 32'(exp_err));
        chk("drop_cnt_o", 32'(drop_cnt_o), exp_drop);
        chk("sat_drop_cnt_o", 32'(s_drop_cnt_o), exp_sdrop);
    endtask

    task automatic chk_rdy(input logic el, input logic er, input logic eu);
        #1;
        chk("l_ready_o", 32'(l_ready_o), 32'(el));
        chk("r_ready_o", 32'(r_ready_o), 32'(er));
        chk("u_ready_o", 32'(u_ready_o), 32'(eu));
    endtask

    task automatic cycle();
        int  nd;
        logic rst;
        nd = illegal(l_valid_i, l_dir_i, LEFT)
           + illegal(r_valid_i, r_dir_i, RIGHT)
           + illegal(u_valid_i, u_dir_i, UP);
        rst = reset;
        @(posedge clk);
        if (rst) begin
            q_l.delete(); q_r.delete(); q_u.delete();
            for (int i = 0; i < 3; i++) begin
                exp_v[i] = 1'b0;
                exp_d[i] = '0;
            end
            exp_err = 1'b0;
            exp_drop = 0;
            exp_sdrop = 0;
        end else begin
            if (nd > 0) exp_err = 1'b1;
            exp_drop  = (exp_drop + nd > 255) ? 255 : exp_drop + nd;
            exp_sdrop = (exp_sdrop + nd > 3) ? 3 : exp_sdrop + nd;
            if (q_l.size() > 0) begin
                exp_d[0] = q_l.pop_front(); exp_v[0] = 1'b1;
            end else if (l_ready_i) exp_v[0] = 1'b0;
            if (q_r.size() > 0) begin
                exp_d[1] = q_r.pop_front(); exp_v[1] = 1'b1;
            end else if (r_ready_i) exp_v[1] = 1'b0;
            if (q_u.size() > 0) begin
                exp_d[2] = q_u.pop_front(); exp_v[2] = 1'b1;
            end else if (u_ready_i) exp_v[2] = 1'b0;
        end
        #1;
        chk_outs();
    endtask

    task automatic idle();
        l_valid_i = 0; r_valid_i = 0; u_valid_i = 0;
        l_dir_i = VOID; r_dir_i = VOID; u_dir_i = VOID;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        l_data_i = '0; r_data_i = '0; u_data_i = '0;
        l_ready_i = 1; r_ready_i = 1; u_ready_i = 1;
        exp_err = 0; exp_drop = 0; exp_sdrop = 0;
        for (int i = 0; i < 3; i++) begin
            exp_v[i] = 0;
            exp_d[i] = '0;
        end
        cycle();
        // ready stays low while reset is high
        l_valid_i = 1; l_dir_i = UP; l_data_i = 32'hA5A5_0001;
        chk_rdy(0, 0, 0);
        cycle();
        reset = 1'b0;
        // single route
        chk_rdy(1, 0, 0);
        q_u.push_back(32'hA5A5_0001);
        cycle();
        idle();
        // contention on UP: L, R, L, R
        for (int i = 0; i < 4; i++) begin
            l_valid_i = 1; l_dir_i = UP; l_data_i = 32'h100 + i;
            r_valid_i = 1; r_dir_i = UP; r_data_i = 32'h200 + i;
            chk_rdy(i % 2 == 0, i % 2 == 1, 0);
            q_u.push_back((i % 2 == 0) ? 32'h100 + i : 32'h200 + i);
            cycle();
        end
        idle();
        // backpressure with no bubble on release
        l_valid_i = 1; l_dir_i = UP; l_data_i = 32'h11;
        chk_rdy(1, 0, 0);
        q_u.push_back(32'h11);
        cycle();
        u_ready_i = 0; l_data_i = 32'h22;
        chk_rdy(0, 0, 0);
        cycle();
        cycle();
        u_ready_i = 1;
        chk_rdy(1, 0, 0);
        q_u.push_back(32'h22);
        cycle();
        idle();
        cycle();
        // full crossbar
        l_valid_i = 1; l_dir_i = RIGHT; l_data_i = 32'h1000_0001;
        r_valid_i = 1; r_dir_i = UP;    r_data_i = 32'h2000_0002;
        u_valid_i = 1; u_dir_i = LEFT;  u_data_i = 32'h3000_0003;
        chk_rdy(1, 1, 1);
        q_r.push_back(32'h1000_0001);
        q_u.push_back(32'h2000_0002);
        q_l.push_back(32'h3000_0003);
        cycle();
        idle();
        cycle();
        // contention on LEFT: candidate R first
        r_valid_i = 1; r_dir_i = LEFT; r_data_i = 32'h44;
        u_valid_i = 1; u_dir_i = LEFT; u_data_i = 32'h55;
        chk_rdy(0, 1, 0);
        q_l.push_back(32'h44);
        cycle();
        idle();
        cycle();
        // illegal routes
        r_valid_i = 1; r_dir_i = RIGHT; r_data_i = 32'hDEAD;
        u_valid_i = 1; u_dir_i = UP;    u_data_i = 32'hBEEF;
        chk_rdy(0, 1, 1);
        cycle();
        idle();
        l_valid_i = 1; l_dir_i = VOID;
        chk_rdy(1, 0, 0);
        cycle();
        l_valid_i = 1; l_dir_i = LEFT;
        r_valid_i = 1; r_dir_i = RIGHT;
        u_valid_i = 1; u_dir_i = UP;
        chk_rdy(1, 1, 1);
        cycle();
        idle();
        l_dir_i = LEFT; r_dir_i = RIGHT; u_dir_i = UP;
        chk_rdy(0, 0, 0);
        cycle();
        idle();
        // fill all outputs while stalled, then reset
        l_ready_i = 0; r_ready_i = 0; u_ready_i = 0;
        l_valid_i = 1; l_dir_i = RIGHT; l_data_i = 32'h61;
        r_valid_i = 1; r_dir_i = UP;    r_data_i = 32'h62;
        u_valid_i = 1; u_dir_i = LEFT;  u_data_i = 32'h63;
        chk_rdy(1, 1, 1);
        q_r.push_back(32'h61);
        q_u.push_back(32'h62);
        q_l.push_back(32'h63);
        cycle();
        idle();
        cycle();
        reset = 1'b1;
        l_valid_i = 1; l_dir_i = UP;
        chk_rdy(0, 0, 0);
        cycle();
        reset = 1'b0;
        idle();
        l_ready_i = 1; r_ready_i = 1; u_ready_i = 1;
        r_valid_i = 1; r_dir_i = LEFT; r_data_i = 32'h66;
        u_valid_i = 1; u_dir_i = LEFT; u_data_i = 32'h77;
        chk_rdy(0, 1, 0);
        q_l.push_back(32'h66);
        cycle();
        idle();
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
